// File: rtl/prim_conv_pkg.sv
// Shared widths, control-port select codes and the phi clipping helper for the
// sector primitive converter.
package prim_conv_pkg;

    localparam int DEF_BW_HS  = 8;
    localparam int DEF_BW_FPH = 13;
    localparam int DEF_BW_DSP = 6;
    localparam int DEF_BW_CNT = 16;
    localparam int DEF_BW_REG = 13;

    typedef enum logic [1:0] {
        SEL_PHINIT = 2'd0,
        SEL_PHDISP = 2'd1,
        SEL_CNT    = 2'd2,
        SEL_RSVD   = 2'd3
    } sel_e;

    // Clamp a signed sum into the unsigned full-precision phi range [0, fmax].
    function automatic int clip_fph(input int sum, input int fmax);
        int res;
        if (sum < 32'sd0) begin
            res = 32'sd0;
        end else if (sum > fmax) begin
            res = fmax;
        end else begin
            res = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/prim_conv_ch.sv
// One chamber: offset/slope config registers, two-stage half-strip to phi pipe,
// saturating hit counter and a read mux for the control port.
module prim_conv_ch
    import prim_conv_pkg::*;
#(
    parameter int ST     = 0,
    parameter int CH     = 0,
    parameter int SEG    = 2,
    parameter int BW_HS  = DEF_BW_HS,
    parameter int BW_FPH = DEF_BW_FPH,
    parameter int BW_DSP = DEF_BW_DSP,
    parameter int BW_CNT = DEF_BW_CNT,
    parameter int BW_REG = DEF_BW_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              endcap,
    input  logic              lat_test,
    input  logic [SEG-1:0]    vpf,
    input  logic [BW_HS-1:0]  hstr [SEG],
    input  logic              wr_en,
    input  logic [1:0]        sel,
    input  logic [BW_REG-1:0] r_in,
    output logic [BW_FPH-1:0] ph [SEG],
    output logic [SEG-1:0]    vl,
    output logic [BW_REG-1:0] rd_val
);

    localparam int BW_PROD = BW_HS + BW_DSP;
    localparam int BW_D    = BW_PROD - 4;
    localparam int SW      = (SEG > 1) ? $clog2(SEG) : 1;
    localparam int PAD     = BW_FPH - 7 - SW;
    localparam int FPH_MAX = (32'sd1 <<< BW_FPH) - 32'sd1;
    localparam logic [2:0] ST3 = 3'(ST);
    localparam logic [3:0] CH4 = 4'(CH);

    logic [BW_FPH-1:0] ph_init_q, ph_init_d;
    logic [BW_DSP-1:0] ph_disp_q, ph_disp_d;
    logic [BW_CNT-1:0] cnt_q, cnt_d;
    logic [SEG-1:0]    vpf1_q, vpf1_d;
    logic              lat1_q, lat1_d;
    logic [BW_D-1:0]   d1_q [SEG];
    logic [BW_D-1:0]   d1_d [SEG];
    logic [BW_FPH-1:0] ph_q [SEG];
    logic [BW_FPH-1:0] ph_d [SEG];
    logic [SEG-1:0]    vl_q, vl_d;

    logic [BW_PROD-1:0]      prod_s [SEG];
    logic signed [BW_FPH+1:0] sum_s [SEG];
    logic [BW_FPH-1:0]       mark_s [SEG];
    logic [BW_CNT:0]         hits_s;
    logic [BW_CNT:0]         cnt_sum_s;

    // Next-state logic: config writes, both pipe stages, hit counter, read mux.
    always_comb begin
        ph_init_d = ph_init_q;
        ph_disp_d = ph_disp_q;
        if (wr_en && (sel == SEL_PHINIT)) begin
            ph_init_d = r_in[BW_FPH-1:0];
        end else if (wr_en && (sel == SEL_PHDISP)) begin
            ph_disp_d = r_in[BW_DSP-1:0];
        end else begin
            ph_init_d = ph_init_q;
        end

        vpf1_d = vpf;
        lat1_d = lat_test;
        vl_d   = vpf1_q;
        hits_s = '0;
        for (int s = 0; s < SEG; s++) begin
            prod_s[s] = BW_PROD'(hstr[s]) * BW_PROD'(ph_disp_q);
            d1_d[s]   = prod_s[s][BW_PROD-1:4];
            if (endcap) begin
                sum_s[s] = {2'b00, ph_init_q} - (BW_FPH+2)'(d1_q[s]);
            end else begin
                sum_s[s] = {2'b00, ph_init_q} + (BW_FPH+2)'(d1_q[s]);
            end
            // Latency-test marker: station, chamber, segment index, MSB-aligned.
            mark_s[s] = {ST3, CH4, SW'(s), {PAD{1'b0}}};
            if (lat1_q) begin
                ph_d[s] = mark_s[s];
            end else begin
                ph_d[s] = BW_FPH'(clip_fph(int'(sum_s[s]), FPH_MAX));
            end
            hits_s = hits_s + (BW_CNT+1)'(vl_q[s]);
        end

        cnt_sum_s = {1'b0, cnt_q} + hits_s;
        if (wr_en && (sel == SEL_CNT)) begin
            cnt_d = '0;
        end else if (cnt_sum_s[BW_CNT]) begin
            cnt_d = '1;
        end else begin
            cnt_d = cnt_sum_s[BW_CNT-1:0];
        end

        case (sel)
            SEL_PHINIT: rd_val = BW_REG'(ph_init_q);
            SEL_PHDISP: rd_val = BW_REG'(ph_disp_q);
            SEL_CNT:    rd_val = cnt_q[BW_REG-1:0];
            default:    rd_val = '0;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_init_q <= '0;
            ph_disp_q <= '0;
            cnt_q     <= '0;
            vpf1_q    <= '0;
            lat1_q    <= 1'b0;
            vl_q      <= '0;
            for (int s = 0; s < SEG; s++) begin
                d1_q[s] <= '0;
                ph_q[s] <= '0;
            end
        end else begin
            ph_init_q <= ph_init_d;
            ph_disp_q <= ph_disp_d;
            cnt_q     <= cnt_d;
            vpf1_q    <= vpf1_d;
            lat1_q    <= lat1_d;
            vl_q      <= vl_d;
            for (int s = 0; s < SEG; s++) begin
                d1_q[s] <= d1_d[s];
                ph_q[s] <= ph_d[s];
            end
        end
    end

    assign ph = ph_q;
    assign vl = vl_q;

endmodule

// File: rtl/prim_conv_sector_pipe.sv
// Sector-wide converter: NST x NCH chamber instances plus the shared control
// port (chamber-select decode, OR read mux, read acknowledge, select error).
module prim_conv_sector_pipe
    import prim_conv_pkg::*;
#(
    parameter int NST    = 6,
    parameter int NCH    = 9,
    parameter int SEG    = 2,
    parameter int BW_HS  = DEF_BW_HS,
    parameter int BW_FPH = DEF_BW_FPH,
    parameter int BW_DSP = DEF_BW_DSP,
    parameter int BW_CNT = DEF_BW_CNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 endcap,
    input  logic                 lat_test,
    input  logic [SEG-1:0]       vpf  [NST][NCH],
    input  logic [BW_HS-1:0]     hstr [NST][NCH][SEG],
    output logic [BW_FPH-1:0]    ph   [NST][NCH][SEG],
    output logic [SEG-1:0]       vl   [NST][NCH],
    input  logic [NST*NCH-1:0]   cs,
    input  logic [1:0]           sel,
    input  logic                 we,
    input  logic                 rd,
    input  logic [12:0]          r_in,
    output logic [12:0]          r_out,
    output logic                 r_ack,
    output logic                 cs_err
);

    localparam int NCS = NST * NCH;
    localparam int CPW = $clog2(NCS + 1);

    logic [12:0]    rd_val_s [NCS];
    logic [12:0]    rd_or_s;
    logic [CPW-1:0] cs_pc_s;
    logic [12:0]    r_out_q, r_out_d;
    logic           r_ack_q, r_ack_d;
    logic           cs_err_q, cs_err_d;

    for (genvar gst = 0; gst < NST; gst++) begin : gen_st
        for (genvar gch = 0; gch < NCH; gch++) begin : gen_ch
            prim_conv_ch #(
                .ST(gst), .CH(gch), .SEG(SEG), .BW_HS(BW_HS), .BW_FPH(BW_FPH),
                .BW_DSP(BW_DSP), .BW_CNT(BW_CNT), .BW_REG(13)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .endcap  (endcap),
                .lat_test(lat_test),
                .vpf     (vpf[gst][gch]),
                .hstr    (hstr[gst][gch]),
                .wr_en   (we && cs[gst*NCH+gch]),
                .sel     (sel),
                .r_in    (r_in),
                .ph      (ph[gst][gch]),
                .vl      (vl[gst][gch]),
                .rd_val  (rd_val_s[gst*NCH+gch])
            );
        end
    end

    // Select decode, OR-combined read data and sticky multi-select error.
    always_comb begin
        rd_or_s = '0;
        cs_pc_s = '0;
        for (int i = 0; i < NCS; i++) begin
            rd_or_s = rd_or_s | (rd_val_s[i] & {13{cs[i]}});
            cs_pc_s = cs_pc_s + CPW'(cs[i]);
        end
        // A write in the same cycle as a read drops the read.
        r_ack_d = rd && !we;
        if (rd && !we) begin
            r_out_d = rd_or_s;
        end else begin
            r_out_d = r_out_q;
        end
        cs_err_d = cs_err_q | ((we || rd) && (cs_pc_s > CPW'(1)));
    end

    // Control-port output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q  <= '0;
            r_ack_q  <= 1'b0;
            cs_err_q <= 1'b0;
        end else begin
            r_out_q  <= r_out_d;
            r_ack_q  <= r_ack_d;
            cs_err_q <= cs_err_d;
        end
    end

    assign r_out  = r_out_q;
    assign r_ack  = r_ack_q;
    assign cs_err = cs_err_q;

endmodule
